// File: rtl/cond_logic_unit.sv
// cond_logic_unit: per-transaction bitwise operation unit with a
// valid/ready handshake on both sides and a single registered output stage.
// Single-beat ops: COND (legacy MSB-conditional XOR/AND), XOR, AND, OR, and
// the reserved codes (result 0). Multi-beat ops: ACC_XOR / ACC_AND fold
// operand A over ACC_LEN accepted beats and emit one result with out_last=1.
// Optional feature: define CLU_PARITY_EN to add out_parity, the XOR-reduction
// of out_data, registered and held together with it.
module cond_logic_unit #(
  parameter int WIDTH   = 8,
  parameter int ACC_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
`ifdef CLU_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  localparam logic [2:0] OP_COND    = 3'd0;
  localparam logic [2:0] OP_XOR     = 3'd1;
  localparam logic [2:0] OP_AND     = 3'd2;
  localparam logic [2:0] OP_OR      = 3'd3;
  localparam logic [2:0] OP_ACC_XOR = 3'd4;
  localparam logic [2:0] OP_ACC_AND = 3'd5;

  // Counter value on the beat that closes a burst.
  localparam logic [7:0] LAST_CNT = 8'(ACC_LEN - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             acc_and_q, acc_and_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;
  logic             accept;

  // Result of a single-beat operation; reserved codes yield zero.
  function automatic logic [WIDTH-1:0] single_op(input logic [2:0] o,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (o)
      OP_COND: r = x[WIDTH-1] ? (x & y) : (x ^ y);
      OP_XOR:  r = x ^ y;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      default: r = '0;
    endcase
    return r;
  endfunction

  // One fold step of the accumulate modes.
  function automatic logic [WIDTH-1:0] fold(input logic is_and,
                                            input logic [WIDTH-1:0] acc,
                                            input logic [WIDTH-1:0] x);
    return is_and ? (acc & x) : (acc ^ x);
  endfunction

  // Backpressure passes straight through: a new beat is taken whenever the
  // output register is empty or being drained this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Next-state logic for the output register and the accumulate FSM.
  always_comb begin
    logic [WIDTH-1:0] f;
    logic             is_and;
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    acc_and_d   = acc_and_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    f           = '0;
    is_and      = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (accept) begin
      if (state_q == IDLE) begin
        if (op == OP_ACC_XOR || op == OP_ACC_AND) begin
          is_and = (op == OP_ACC_AND);
          f      = fold(is_and, is_and ? '1 : '0, a);
          if (ACC_LEN == 1) begin
            out_valid_d = 1'b1;
            out_data_d  = f;
            out_last_d  = 1'b1;
          end else begin
            acc_d     = f;
            acc_and_d = is_and;
            cnt_d     = 8'd1;
            busy_d    = 1'b1;
            state_d   = ACC;
          end
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = single_op(op, a, b);
          out_last_d  = 1'b0;
        end
      end else begin
        // Mid-burst the op input is ignored; the latched fold mode applies.
        f = fold(acc_and_q, acc_q, a);
        if (cnt_q == LAST_CNT) begin
          out_valid_d = 1'b1;
          out_data_d  = f;
          out_last_d  = 1'b1;
          acc_d       = '0;
          cnt_d       = 8'd0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          acc_d = f;
          cnt_d = cnt_q + 8'd1;
        end
      end
    end
  end

  // State and output registers; reset discards any partial burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      acc_q       <= '0;
      acc_and_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      acc_and_q   <= acc_and_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

`ifdef CLU_PARITY_EN
  logic out_parity_q;

  // Parity travels with out_data, so it is loaded from the same next value.
  always_ff @(posedge clk) begin
    if (rst) out_parity_q <= 1'b0;
    else     out_parity_q <= ^out_data_d;
  end

  assign out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_cond_logic_unit.sv
// Testbench for cond_logic_unit: directed cases plus randomized traffic,
// checked through an expected-result queue and an independent monitor.
module tb_cond_logic_unit;

  localparam int WIDTH   = 8;
  localparam int ACC_LEN = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [2:0]       op = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;
`ifdef CLU_PARITY_EN
  logic             out_parity;
`endif

  cond_logic_unit #(.WIDTH(WIDTH), .ACC_LEN(ACC_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
`ifdef CLU_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
    int               cyc;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] burst[$];
  int               burst_op;
  int               cyc = 0;
  int               total = 0;
  int               bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference result for single-beat ops, written bit by bit.
  function automatic logic [WIDTH-1:0] ref_single(input int o, input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (o)
        0: r[i] = x[WIDTH-1] ? (x[i] & y[i]) : (x[i] ^ y[i]);
        1: r[i] = x[i] ^ y[i];
        2: r[i] = x[i] & y[i];
        3: r[i] = x[i] | y[i];
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic push_exp(input logic [WIDTH-1:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
  endtask

  // Model of one accepted beat: bursts are collected whole, then folded.
  task automatic model_accept(input int o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    if (burst.size() == 0) begin
      if (o == 4 || o == 5) begin
        burst_op = o;
        burst.push_back(x);
      end else begin
        push_exp(ref_single(o, x, y), 1'b0);
      end
    end else begin
      burst.push_back(x);
    end
    if (burst.size() == ACC_LEN) begin
      r = (burst_op == 5) ? '1 : '0;
      foreach (burst[i]) r = (burst_op == 5) ? (r & burst[i]) : (r ^ burst[i]);
      push_exp(r, 1'b1);
      burst.delete();
    end
  endtask

  // Drive one cycle of stimulus; record the beat if the DUT takes it.
  task automatic drive(input logic v, input int o, input logic [WIDTH-1:0] xa,
                       input logic [WIDTH-1:0] xb, input logic ordy);
    @(negedge clk);
    rst = 1'b0; in_valid = v; op = 3'(o); a = xa; b = xb; out_ready = ordy;
    #1;
    chk("busy", busy, (burst.size() != 0));
    if (v && in_ready) model_accept(o, xa, xb);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    burst.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
`ifdef CLU_PARITY_EN
    chk("rst_parity", out_parity, 0);
`endif
  endtask

  // Monitor: latency on first sight, stability while held, contents on transfer.
  initial begin
    logic             seen;
    logic [WIDTH-1:0] held_d;
    logic             held_l;
    exp_t             e;
    seen = 1'b0; held_d = '0; held_l = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        seen = 1'b0;
      end else if (out_valid) begin
        chk("in_ready_vs_out_ready", in_ready, out_ready);
        if (!seen) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            chk("latency", cyc, exp_q[0].cyc);
          end
          seen = 1'b1; held_d = out_data; held_l = out_last;
        end else begin
          chk("hold_data", out_data, held_d);
          chk("hold_last", out_last, held_l);
        end
        if (out_ready) begin
          seen = 1'b0;
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_last", out_last, e.last);
`ifdef CLU_PARITY_EN
            chk("out_parity", out_parity, ^e.data);
`endif
          end
        end
      end else begin
        seen = 1'b0;
        chk("idle_in_ready", in_ready, 1);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    do_reset();

    // COND: XOR branch then AND branch.
    drive(1, 0, 8'h35, 8'h0F, 1);
    drive(1, 0, 8'hB5, 8'h0F, 1);
    drive(0, 0, 8'h00, 8'h00, 1);

    // ACC_XOR burst of four beats.
    drive(1, 4, 8'h01, 8'h00, 1);
    drive(1, 4, 8'h02, 8'h00, 1);
    drive(1, 4, 8'h04, 8'h00, 1);
    drive(1, 4, 8'h08, 8'h00, 1);
    drive(0, 0, 8'h00, 8'h00, 1);

    // ACC_AND with op changed mid-burst.
    drive(1, 5, 8'hFF, 8'h00, 1);
    drive(1, 1, 8'hF0, 8'h55, 1);
    drive(1, 1, 8'h3C, 8'h55, 1);
    drive(1, 1, 8'h30, 8'h55, 1);
    drive(0, 0, 8'h00, 8'h00, 1);

    // OR under three cycles of backpressure, with a beat offered meanwhile.
    drive(1, 3, 8'h50, 8'h0A, 0);
    drive(1, 1, 8'h12, 8'h34, 0);
    drive(1, 1, 8'h12, 8'h34, 0);
    drive(1, 1, 8'h12, 8'h34, 0);
    drive(1, 1, 8'h12, 8'h34, 1);
    drive(0, 0, 8'h00, 8'h00, 1);

    // Reset mid-burst, then a fresh burst.
    drive(1, 4, 8'hAA, 8'h00, 1);
    drive(1, 4, 8'h0C, 8'h00, 1);
    do_reset();
    drive(1, 4, 8'h11, 8'h00, 1);
    drive(1, 4, 8'h22, 8'h00, 1);
    drive(1, 4, 8'h44, 8'h00, 1);
    drive(1, 4, 8'h88, 8'h00, 1);

    // Reserved op.
    drive(1, 6, 8'hFF, 8'hFF, 1);
    drive(1, 7, 8'hA5, 8'h5A, 1);
    drive(0, 0, 8'h00, 8'h00, 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        drive(($urandom_range(0, 3) != 0), $urandom_range(0, 7),
              WIDTH'($urandom), WIDTH'($urandom), ($urandom_range(0, 9) < 7));
      end
    end

    // Drain, bounded.
    for (int i = 0; i < 20; i++) drive(0, 0, 8'h00, 8'h00, 1);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cond_logic_unit.md
Name: cond_logic_unit

Overview:
Parametrised, pipelined successor to the fixed 8-bit conditional XOR/AND block. Selects a bitwise operation per transaction: the legacy MSB-conditional mode, plain XOR, AND or OR, and multi-beat fold (accumulate) modes. Operands and results move over valid/ready handshakes. Sits between the tile's input pins and output pins, with a single registered output stage.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)
ACC_LEN, 4, beats per accumulate burst (legal range 1..255)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  operation select, sampled on accept
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts result
out_data  output  WIDTH  result
out_last  output  1  result closes an accumulate burst
busy  output  1  accumulate burst in progress

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_data=0, out_last=0, busy=0; state=IDLE; beat counter=0; accumulator=0. Any partial burst is discarded.
- Accept condition: in_valid & in_ready. Output transfer: out_valid & out_ready.
- in_ready = !out_valid | out_ready. Combinational pass-through of backpressure; no skid buffer.
- op encoding:
  - 0 COND: per bit, a^b if a[WIDTH-1]==0, else a&b. This generalises the legacy rule to WIDTH.
  - 1 XOR: a^b.
  - 2 AND: a&b.
  - 3 OR: a|b.
  - 4 ACC_XOR: fold of a over ACC_LEN beats, seed 0.
  - 5 ACC_AND: fold of a over ACC_LEN beats, seed all-ones.
  - 6, 7 reserved: result 0, single-beat.
  - b is ignored in ops 4 and 5.
- Single-beat ops (0-3, 6, 7): result registered on accept. out_valid=1 the next cycle, with out_last=0. Latency 1 cycle.
- Accumulate FSM states:
  - IDLE: an accept with op 4/5 latches op into acc_op, sets acc = seed op a, counter=1, busy=1, goes to ACC. If ACC_LEN==1, the result is emitted immediately and the FSM stays in IDLE.
  - ACC: each accept folds a into acc using acc_op; the op input is ignored. counter increments.
  - On the accept with counter==ACC_LEN-1: out_data = final fold, out_valid=1 and out_last=1 next cycle. counter=0, busy=0, state returns to IDLE.
- No intermediate outputs during a burst. in_ready follows the same formula throughout.
- Output hold: while out_valid & !out_ready, out_data and out_last stay stable and in_ready=0.
- Back-to-back operation: with out_ready held at 1, one accept per cycle is sustained. A result transfers in the same cycle the next result is registered.
- Reset mid-burst: the burst is discarded, with no output. The next op 4/5 accept starts a fresh burst.
- Arithmetic: purely bitwise, with no carries. Counter width is 8 bits and wraps only via the ACC_LEN compare.

Optional Feature:
Macro CLU_PARITY_EN.
- Defined: adds port out_parity (output, 1 bit) = XOR-reduction of out_data. It is registered with out_data, held with it under backpressure, and reset to 0.
- Undefined: the port is absent; behaviour is otherwise identical.

Test Plan:
- WIDTH=8, op=0, a=0x35, b=0x0F -> out_data=0x3A (XOR branch). Then a=0xB5, b=0x0F -> 0x05 (AND branch). Each with out_valid one cycle after accept and out_last=0.
- op=4, ACC_LEN=4, a=0x01,0x02,0x04,0x08 on consecutive cycles -> single result 0x0F with out_last=1, one cycle after the 4th accept. busy=1 from the 1st through the 4th accept.
- op=5, a=0xFF,0xF0,0x3C,0x30, with op driven to 1 on beats 2-4 -> result 0x30 (op change ignored mid-burst), out_last=1.
- out_ready=0 for 3 cycles after op=3, a=0x50, b=0x0A -> out_data holds 0x5A and in_ready=0. out_ready=1 -> transfer occurs, and in_ready rises in that same cycle.
- op=4, 2 beats accepted, then rst=1 for 1 cycle -> out_valid=0, busy=0. New burst 0x11,0x22,0x44,0x88 -> 0xFF, uncontaminated by the discarded beats.
- op=6, a=0xFF, b=0xFF -> out_data=0x00. With CLU_PARITY_EN defined, the 0x3A case gives out_parity=0 and 0x05 gives out_parity=0.
